// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: MISR compaction of CUT responses plus a golden-signature compare.
// Define BIST_CYCLE_CHECK_EN to count compactions and also require CYCLES==EXP_CYCLES for PASS.
module bist_response_analyzer #(
    parameter int           W          = 8,
    parameter logic [W-1:0] POLY       = 8'h1D,
    parameter logic [W-1:0] SEED       = 8'hFF,
    parameter logic [W-1:0] GOLDEN     = 8'hE3,
    parameter int           EXP_CYCLES = 90
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic         RUNNING,
    input  logic         BIST_END,
    input  logic [W-1:0] RESP,
    output logic [W-1:0] SIGNATURE,
    output logic [7:0]   CYCLES,
    output logic         DONE,
    output logic         PASS
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic [W-1:0] misr_next;
    logic         done_q;
    logic         done_d;
    logic         pass_q;
    logic         pass_d;
    logic         load_seed;
    logic         compact;
    logic         sig_match;
    logic         cycle_ok;

    // Shift left, fold the outgoing MSB back through the taps, then absorb the response word.
    assign misr_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ RESP;
    assign sig_match = (sig_q == GOLDEN);

    // START restarts from any state and outranks BIST_END.
    assign load_seed = START;
    assign compact   = (state_q == ST_ACTIVE) && RUNNING && !START;

    always_comb begin
        state_d = state_q;
        if (load_seed) begin
            state_d = ST_ACTIVE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_ACTIVE:  state_d = BIST_END ? ST_COMPARE : ST_ACTIVE;
                ST_COMPARE: state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sig_d  = sig_q;
        done_d = done_q;
        pass_d = pass_q;
        if (load_seed) begin
            sig_d  = SEED;
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (compact) begin
            sig_d = misr_next;
        end else if (state_q == ST_COMPARE) begin
            done_d = 1'b1;
            pass_d = sig_match && cycle_ok;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef BIST_CYCLE_CHECK_EN
    localparam logic [31:0] EXP_COUNT = 32'(EXP_CYCLES);

    logic [7:0] cycle_cnt;

    // Saturating count of compacted cycles; 255 only matches if EXP_CYCLES is 255.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cycle_cnt <= 8'd0;
        end else if (load_seed) begin
            cycle_cnt <= 8'd0;
        end else if (compact && (cycle_cnt != 8'hFF)) begin
            cycle_cnt <= cycle_cnt + 8'd1;
        end
    end

    assign cycle_ok = ({24'd0, cycle_cnt} == EXP_COUNT);
    assign CYCLES   = cycle_cnt;
`else
    assign cycle_ok = 1'b1;
    assign CYCLES   = 8'd0;
`endif

    assign SIGNATURE = sig_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench for bist_response_analyzer against a GF(2) polynomial reference model.
module tb_bist_response_analyzer;

    localparam int         W          = 8;
    localparam logic [7:0] POLY       = 8'h1D;
    localparam logic [7:0] SEED       = 8'hFF;
    localparam logic [7:0] GOLDEN     = 8'hE3;
    localparam int         EXP_CYCLES = 90;

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b1;
    logic       START    = 1'b0;
    logic       RUNNING  = 1'b0;
    logic       BIST_END = 1'b0;
    logic [7:0] RESP     = 8'h00;
    logic [7:0] SIGNATURE;
    logic [7:0] CYCLES;
    logic       DONE;
    logic       PASS;

    bist_response_analyzer #(
        .W(W), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .EXP_CYCLES(EXP_CYCLES)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .RUNNING(RUNNING), .BIST_END(BIST_END),
        .RESP(RESP), .SIGNATURE(SIGNATURE), .CYCLES(CYCLES), .DONE(DONE), .PASS(PASS)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: signature as a polynomial over GF(2), test progress as plain flags.
    logic [7:0] m_sig;
    int         m_count;
    bit         m_armed;
    bit         m_pending;
    bit         m_valid;
    bit         m_pass;

    function automatic logic [7:0] gf_step(input logic [7:0] s, input logic [7:0] r);
        int v;
        v = int'(s) * 2;
        if (v > 255) v = (v - 256) ^ int'(POLY);
        return v[7:0] ^ r;
    endfunction

    function automatic logic [7:0] exp_cycles();
`ifdef BIST_CYCLE_CHECK_EN
        return m_count[7:0];
`else
        return 8'd0;
`endif
    endfunction

    function automatic bit cycles_ok();
`ifdef BIST_CYCLE_CHECK_EN
        return m_count == EXP_CYCLES;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_sig = 8'h00; m_count = 0;
        m_armed = 0; m_pending = 0; m_valid = 0; m_pass = 0;
    endtask

    // Advance the model with the currently driven inputs, then let the DUT see the same edge.
    task automatic tick();
        if (START) begin
            m_sig = SEED; m_count = 0;
            m_armed = 1; m_pending = 0; m_valid = 0; m_pass = 0;
        end else if (m_armed) begin
            if (RUNNING) begin
                m_sig = gf_step(m_sig, RESP);
                if (m_count < 255) m_count++;
            end
            if (BIST_END) begin
                m_armed = 0; m_pending = 1;
            end
        end else if (m_pending) begin
            m_pending = 0; m_valid = 1;
            m_pass = (m_sig == GOLDEN) && cycles_ok();
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic start_test();
        START = 1; RUNNING = 0; BIST_END = 0;
        tick();
        START = 0;
    endtask

    task automatic end_test();
        RUNNING = 0; BIST_END = 1;
        tick();
        BIST_END = 0;
        tick();
    endtask

    task automatic test_reset();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {8'h00, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got sig=%h cyc=%0d done=%b pass=%b, expected 00/0/0/0", SIGNATURE, CYCLES, DONE, PASS);
        end
        RESET = 0;
        RUNNING = 1; RESP = 8'h5A;
        tick(); tick();
        RUNNING = 0;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL idle_ignores_running: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_reset_mid_active();
        start_test();
        RUNNING = 1;
        for (int i = 0; i < 5; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        #3 RESET = 1;
        model_reset();
        #1;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {8'h00, 8'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset_mid_active: got %h/%0d/%b/%b expected 00/0/0/0", SIGNATURE, CYCLES, DONE, PASS);
        end
        @(posedge CLK);
        #1 RESET = 0;
        for (int i = 0; i < 3; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        RUNNING = 0;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_single(input logic [7:0] r, input string name);
        start_test();
        RUNNING = 1; RESP = r;
        tick();
        RUNNING = 0; BIST_END = 1;
        tick();
        BIST_END = 0;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL %s_compare_cycle: got %h/%0d/%b/%b expected %h/%0d/%b/%b", name, SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
        tick();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL %s_result: got %h/%0d/%b/%b expected %h/%0d/%b/%b", name, SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_simultaneous();
        start_test();
        RUNNING = 1; RESP = 8'h00; BIST_END = 1;
        tick();
        RUNNING = 0; BIST_END = 0;
        tick();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL simultaneous_end: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    // Steer the final response so the signature lands exactly on GOLDEN after n compactions.
    task automatic test_cycle_count(input int n);
        start_test();
        RUNNING = 1;
        for (int i = 0; i < n - 1; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        RESP = gf_step(m_sig, 8'h00) ^ GOLDEN;
        BIST_END = 1;
        tick();
        RUNNING = 0; BIST_END = 0;
        tick();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL cycle_count_%0d: got %h/%0d/%b/%b expected %h/%0d/%b/%b", n, SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_restart_done();
        test_single(8'h00, "pre_restart");
        START = 1; BIST_END = 1; RUNNING = 1; RESP = 8'h77;
        tick();
        START = 0; BIST_END = 0; RUNNING = 0;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL restart_in_done: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
        end_test();
    endtask

    task automatic test_restart_active();
        start_test();
        RUNNING = 1;
        for (int i = 0; i < 3; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        START = 1; BIST_END = 1;
        tick();
        START = 0; BIST_END = 0; RUNNING = 0;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL restart_in_active: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
        tick(); tick();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL end_ignored_on_restart: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
        end_test();
    endtask

    task automatic test_bist_end_idle();
        RESET = 1;
        model_reset();
        @(posedge CLK);
        #1 RESET = 0;
        BIST_END = 1; RUNNING = 1; RESP = 8'h3C;
        tick(); tick(); tick();
        BIST_END = 0; RUNNING = 0;
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL bist_end_in_idle: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_long_bist_end();
        start_test();
        RUNNING = 1;
        for (int i = 0; i < 4; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        BIST_END = 1;
        for (int i = 0; i < 4; i++) begin
            RESP = 8'($urandom);
            tick();
            vectors++;
            if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
                miscompares++;
                $display("[TB] FAIL long_bist_end_%0d: got %h/%0d/%b/%b expected %h/%0d/%b/%b", i, SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
            end
        end
        BIST_END = 0; RUNNING = 0;
    endtask

    task automatic test_back_to_back();
        test_single(8'h00, "b2b_first");
        start_test();
        RUNNING = 1;
        for (int i = 0; i < 6; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        end_test();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL back_to_back: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_saturation();
        start_test();
        RUNNING = 1;
        for (int i = 0; i < 300; i++) begin
            RESP = 8'($urandom);
            tick();
        end
        end_test();
        vectors++;
        if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
            miscompares++;
            $display("[TB] FAIL saturation: got %h/%0d/%b/%b expected %h/%0d/%b/%b", SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 8; run++) begin
            int len;
            len = int'($urandom_range(1, 100));
            start_test();
            for (int i = 0; i < len; i++) begin
                RUNNING = ($urandom_range(0, 9) < 7);
                RESP = 8'($urandom);
                tick();
                vectors++;
                if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
                    miscompares++;
                    $display("[TB] FAIL random_run%0d_cycle%0d: got %h/%0d/%b/%b expected %h/%0d/%b/%b", run, i, SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
                end
            end
            end_test();
            vectors++;
            if ({SIGNATURE, CYCLES, DONE, PASS} !== {m_sig, exp_cycles(), m_valid, m_pass}) begin
                miscompares++;
                $display("[TB] FAIL random_run%0d_result: got %h/%0d/%b/%b expected %h/%0d/%b/%b", run, SIGNATURE, CYCLES, DONE, PASS, m_sig, exp_cycles(), m_valid, m_pass);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_reset_mid_active();
        test_single(8'h00, "resp00_pass");
        test_single(8'h01, "resp01_fail");
        test_simultaneous();
        test_cycle_count(EXP_CYCLES);
        test_cycle_count(EXP_CYCLES - 1);
        test_restart_done();
        test_restart_active();
        test_bist_end_idle();
        test_long_bist_end();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
